clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel, runtime-programmable clock divider driven from the 100 MHz board clock.
- Generates NUM_CH independent divided clocks, each with a one-cycle tick enable at the start of every period.
- Divide ratio and enable per channel are reprogrammed through a valid/ready config port.
- Updates take effect only at period boundaries, so no channel ever emits a runt pulse.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 16, width of divide value and period counter.
- DEFAULT_DIV, 100, divide value loaded into every channel at reset (100 MHz -> 1 MHz).
- RESET_EN, {NUM_CH{1'b1}}, per-channel enable mask loaded at reset.

Ports:
- clk_100MHz  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; transfer occurs when cfg_valid && cfg_ready.
- cfg_ch  in  CH_W=max(1,$clog2(NUM_CH))  target channel.
- cfg_div  in  CNT_W  new divide value D.
- cfg_en  in  1  new channel enable.
- clk_out  out  NUM_CH  divided clocks (registered).
- tick  out  NUM_CH  one-cycle pulse, first cycle of each period (registered).
- active  out  NUM_CH  currently effective enable per channel (registered).

Behaviour:
- Reset (rst=1 at an edge):
  - Every channel loads D=DEFAULT_DIV and en=RESET_EN[i].
  - Pending flags cleared; clk_out=0, tick=0, active=RESET_EN.
- Clamp: effective D = max(cfg_div, 2). Values 0 and 1 behave exactly as 2.
- Period of an enabled channel:
  - Lasts exactly D cycles.
  - clk_out is high for H=ceil(D/2) cycles, then low for D-H cycles.
  - tick is high in the first cycle of the period, coincident with the clk_out rise.
  - Odd D gives the extra cycle to the high phase.
- Start latency:
  - On the first edge with rst=0, an enabled channel starts a period: clk_out=1, tick=1.
  - A channel enabled from the disabled state does the same on the edge that applies the write.
- Disabled channel: period counter held, clk_out=0, tick=0, active=0.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch], combinational from registers only; no path from cfg_valid.
  - cfg_ch >= NUM_CH: cfg_ready=1 and the write is accepted and discarded.
- Write to a disabled channel: applied on the accepting edge itself; pending is never set.
- Write to an enabled channel:
  - Values stored in the shadow register and pending[ch] set.
  - Applied on the edge that ends the current period, which is the first edge at which the period would wrap.
  - pending is cleared on that same edge.
  - If the new en=1, the new period starts immediately with the new D.
  - If the new en=0, clk_out/tick stay 0 from that edge on.
- A write accepted in the last cycle of a period is applied at the end of the following period, not the current one.
- Channels are fully independent; simultaneous boundaries on several channels are legal.
- Config changes only ever take effect at a boundary.
- Reset mid-period aborts all channels immediately and discards pending writes.

Decomposition:
- Package clk_div_pkg holds:
  - MIN_DIV=2 and DEFAULT_DIV.
  - Function half_up(d) = (d+1)>>1.
  - Typedef div_t = logic [CNT_W-1:0].
- Sub-module clk_div_channel holds one channel's counter, shadow/pending registers, clamp and output regs; it is instantiated NUM_CH times via generate.
- Top level contains only the cfg_ch decode and the cfg_ready mux.

Test Plan:
- Reset release, defaults → each channel: tick every 100 cycles, clk_out 50 high/50 low, first tick on the first edge after rst falls.
- Ch1 disabled, write D=5 en=1 → next edge tick=1; clk_out pattern 1,1,1,0,0 repeating; cfg_ready never drops.
- Ch0 at D=10, write D=4 at cycle 3 of a period:
  - cfg_ready for ch0 is low for the remaining 7 cycles.
  - The current period completes all 10 cycles, then 4-cycle periods (2 high/2 low) follow.
  - A second write during the pending window stalls.
- Write D=0 and D=1 → both behave as D=2: clk_out toggles every cycle, tick every 2 cycles.
- Ch2 at D=8, write en=0 during the high phase → clk_out finishes the 4-high/4-low period, then stays 0; active drops at the boundary; next write en=1 restarts immediately.
- rst asserted mid-period with a write pending → the next edge gives all outputs 0 and pending cleared; after release, D=DEFAULT_DIV and the pending value is not applied.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants, divide-value type and helpers for the
//               multi-channel clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int CNT_W       = 16;
    localparam int MIN_DIV     = 2;
    localparam int DEFAULT_DIV = 100;

    typedef logic [CNT_W-1:0] div_t;

    // Length of the high phase: odd divide values give the extra cycle to high.
    function automatic div_t half_up(input div_t d);
        logic [CNT_W:0] w_sum;
        w_sum = {1'b0, d} + {{CNT_W{1'b0}}, 1'b1};
        return w_sum[CNT_W:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi_if
// Description : valid/ready configuration port of the multi-channel divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_en;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_en,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_channel
// Description : One divider channel: period counter, shadow config and
//               boundary-aligned update of divide value and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_channel #(
    parameter int CNT_W       = clk_div_pkg::CNT_W,
    parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    parameter bit RESET_EN    = 1'b1
) (
    input  wire logic             clk_100MHz,
    input  wire logic             rst,
    input  wire logic             i_wr,
    input  wire logic [CNT_W-1:0] i_div,
    input  wire logic             i_en,
    output logic                  o_pending,
    output logic                  o_clk,
    output logic                  o_tick,
    output logic                  o_active
);
    import clk_div_pkg::*;

    localparam logic [CNT_W-1:0] C_MIN_DIV = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_RST_DIV =
        (DEFAULT_DIV < MIN_DIV) ? C_MIN_DIV : CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_div, r_cnt, r_sh_div;
    logic             r_en, r_pend, r_sh_en, r_clk, r_tick;

    logic [CNT_W-1:0] w_div_nxt, w_cnt_nxt, w_sh_div_nxt;
    logic             w_en_nxt, w_pend_nxt, w_sh_en_nxt, w_clk_nxt, w_tick_nxt;
    logic [CNT_W-1:0] w_wr_div, w_half, w_cnt_inc;
    logic             w_wrap;

    assign w_wr_div  = (i_div < C_MIN_DIV) ? C_MIN_DIV : i_div;
    assign w_half    = half_up(r_div);
    assign w_cnt_inc = r_cnt + C_ONE;
    assign w_wrap    = (r_cnt == (r_div - C_ONE));

    always_comb begin
        w_div_nxt    = r_div;
        w_cnt_nxt    = r_cnt;
        w_en_nxt     = r_en;
        w_pend_nxt   = r_pend;
        w_sh_div_nxt = r_sh_div;
        w_sh_en_nxt  = r_sh_en;
        w_clk_nxt    = 1'b0;
        w_tick_nxt   = 1'b0;

        if (r_en) begin
            if (w_wrap) begin
                // Period boundary: the only point where a queued config lands.
                if (r_pend) begin
                    w_div_nxt  = r_sh_div;
                    w_en_nxt   = r_sh_en;
                    w_pend_nxt = 1'b0;
                end
                w_cnt_nxt = '0;
                if (!r_pend || r_sh_en) begin
                    w_clk_nxt  = 1'b1;
                    w_tick_nxt = 1'b1;
                end
            end else begin
                w_cnt_nxt = w_cnt_inc;
                w_clk_nxt = (w_cnt_inc < w_half);
            end
            if (i_wr) begin
                w_sh_div_nxt = w_wr_div;
                w_sh_en_nxt  = i_en;
                w_pend_nxt   = 1'b1;
            end
        end else if (i_wr) begin
            w_div_nxt  = w_wr_div;
            w_en_nxt   = i_en;
            w_cnt_nxt  = '0;
            w_clk_nxt  = i_en;
            w_tick_nxt = i_en;
        end
    end

    // Counter resets to the last position so the first edge after reset wraps.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            r_div    <= C_RST_DIV;
            r_cnt    <= C_RST_DIV - C_ONE;
            r_en     <= RESET_EN;
            r_pend   <= 1'b0;
            r_sh_div <= C_RST_DIV;
            r_sh_en  <= 1'b0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_div    <= w_div_nxt;
            r_cnt    <= w_cnt_nxt;
            r_en     <= w_en_nxt;
            r_pend   <= w_pend_nxt;
            r_sh_div <= w_sh_div_nxt;
            r_sh_en  <= w_sh_en_nxt;
            r_clk    <= w_clk_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    assign o_pending = r_pend;
    assign o_clk     = r_clk;
    assign o_tick    = r_tick;
    assign o_active  = r_en;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi
// Description : NUM_CH runtime-programmable clock dividers sharing one
//               valid/ready configuration port.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi #(
    parameter int              NUM_CH      = 4,
    parameter int              CNT_W       = clk_div_pkg::CNT_W,
    parameter int              DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    parameter logic [NUM_CH-1:0] RESET_EN  = {NUM_CH{1'b1}}
) (
    input  wire logic        clk_100MHz,
    input  wire logic        rst,
    clk_div_multi_if.slave   cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] active
);
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_pend;
    logic              w_accept;

    // Out-of-range channels select nothing, so they stay ready and drop writes.
    always_comb begin
        w_sel         = '0;
        cfg.cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cfg.cfg_ch) == i) begin
                w_sel[i]      = 1'b1;
                cfg.cfg_ready = ~w_pend[i];
            end
        end
    end

    assign w_accept = cfg.cfg_valid & cfg.cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .RESET_EN    (RESET_EN[g])
        ) u_ch (
            .clk_100MHz (clk_100MHz),
            .rst        (rst),
            .i_wr       (w_accept & w_sel[g]),
            .i_div      (cfg.cfg_div),
            .i_en       (cfg.cfg_en),
            .o_pending  (w_pend[g]),
            .o_clk      (clk_out[g]),
            .o_tick     (tick[g]),
            .o_active   (active[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_multi
// Description : Self-checking bench for clk_div_multi with a time-based
//               behavioural model and directed plus random configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int DEF    = 100;

    logic clk_100MHz = 1'b0;
    logic rst        = 1'b1;
    always #5 clk_100MHz = ~clk_100MHz;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) u_if ();
    logic [NUM_CH-1:0] clk_out, tick, active;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF),
        .RESET_EN    ({NUM_CH{1'b1}})
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .cfg        (u_if.slave),
        .clk_out    (clk_out),
        .tick       (tick),
        .active     (active)
    );

    int checks = 0;
    int errors = 0;

    // Model: each channel remembers the absolute edge index its period began.
    longint cyc = 0;
    int     m_d     [NUM_CH];
    bit     m_en    [NUM_CH];
    bit     m_pend  [NUM_CH];
    int     m_sd    [NUM_CH];
    bit     m_se    [NUM_CH];
    longint m_start [NUM_CH];
    logic [NUM_CH-1:0] e_clk, e_tick, e_act;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int clampv(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic bit m_ready(input int ch);
        return (ch >= NUM_CH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic model_edge(input bit r, input bit acc, input int wch, input int wd, input bit we);
        cyc++;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit was_en;
            if (r) begin
                m_d[ch] = DEF; m_en[ch] = 1'b1; m_pend[ch] = 1'b0; m_start[ch] = -1;
                e_clk[ch] = 1'b0; e_tick[ch] = 1'b0; e_act[ch] = 1'b1;
                continue;
            end
            was_en = m_en[ch];
            if (was_en && (m_start[ch] == -1 || cyc - m_start[ch] == longint'(m_d[ch]))) begin
                if (m_pend[ch]) begin
                    m_d[ch] = m_sd[ch]; m_en[ch] = m_se[ch]; m_pend[ch] = 1'b0;
                end
                m_start[ch] = m_en[ch] ? cyc : -2;
            end
            if (acc && wch == ch) begin
                if (!was_en) begin
                    m_d[ch] = clampv(wd); m_en[ch] = we; m_start[ch] = we ? cyc : -2;
                end else begin
                    m_sd[ch] = clampv(wd); m_se[ch] = we; m_pend[ch] = 1'b1;
                end
            end
            e_act[ch]  = m_en[ch];
            e_tick[ch] = m_en[ch] && (m_start[ch] == cyc);
            e_clk[ch]  = m_en[ch] && (cyc - m_start[ch] < longint'((m_d[ch] + 1) / 2));
        end
    endtask

    // One clock: check ready, advance the model on the edge, compare outputs.
    task automatic step();
        bit acc;
        #1;
        check("cfg_ready", u_if.cfg_ready, m_ready(int'(u_if.cfg_ch)));
        acc = u_if.cfg_valid && m_ready(int'(u_if.cfg_ch));
        @(posedge clk_100MHz);
        model_edge(rst, acc, int'(u_if.cfg_ch), int'(u_if.cfg_div), u_if.cfg_en);
        #1;
        check("clk_out", clk_out, e_clk);
        check("tick", tick, e_tick);
        check("active", active, e_act);
    endtask

    task automatic wr(input int ch, input int d, input bit e, output int stalls);
        bit a;
        stalls = 0;
        u_if.cfg_valid = 1'b1;
        u_if.cfg_ch    = 2'(ch);
        u_if.cfg_div   = 16'(d);
        u_if.cfg_en    = e;
        forever begin
            a = m_ready(ch);
            step();
            if (a) break;
            stalls++;
            if (stalls > 300) begin
                check("wr_timeout", stalls, 0);
                break;
            end
        end
        u_if.cfg_valid = 1'b0;
    endtask

    int st, n, hi, tk;
    logic [4:0] pat;

    initial begin
        u_if.cfg_valid = 1'b0; u_if.cfg_ch = '0; u_if.cfg_div = '0; u_if.cfg_en = 1'b0;
        rst = 1'b1;
        @(posedge clk_100MHz);
        model_edge(1'b1, 1'b0, 0, 0, 1'b0);
        #1;
        step(); step();
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_active", active, 3'b111);

        // Defaults: 100-cycle periods, 50 high, first tick on the release edge.
        rst = 1'b0;
        hi = 0; tk = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 0) begin
                check("first_tick", tick, 3'b111);
                check("first_clk", clk_out, 3'b111);
            end
            hi += int'(clk_out[0]);
            tk += int'(tick[0]);
        end
        check("def_high_cycles", hi, 50);
        check("def_ticks", tk, 1);

        // Disable ch1 at its boundary, then re-enable with D=5.
        wr(1, 5, 1'b0, st);
        n = 0;
        while (m_en[1] && n < 300) begin step(); n++; end
        check("ch1_disabled", active[1], 0);
        idle_steps(3);
        wr(1, 5, 1'b1, st);
        check("ch1_no_stall", st, 0);
        check("ch1_start_tick", tick[1], 1);
        pat = {4'b0, clk_out[1]};
        for (int i = 0; i < 4; i++) begin
            step();
            pat = {pat[3:0], clk_out[1]};
        end
        check("ch1_pattern", pat, 5'b11100);

        // ch0 to D=10, then D=4 mid-period and a second write that stalls.
        wr(0, 10, 1'b1, st);
        n = 0;
        while (m_pend[0] && n < 300) begin step(); n++; end
        step(); step();
        wr(0, 4, 1'b1, st);
        check("ch0_first_stall", st, 0);
        wr(0, 4, 1'b1, st);
        check("ch0_second_stall", st, 7);
        idle_steps(20);

        // D=0 and D=1 both behave as D=2.
        wr(1, 0, 1'b1, st);
        idle_steps(12);
        wr(1, 1, 1'b1, st);
        idle_steps(12);
        hi = 0; tk = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            hi += int'(clk_out[1]);
            tk += int'(tick[1]);
        end
        check("d2_high", hi, 4);
        check("d2_ticks", tk, 4);

        // ch2 D=8, disable in the high phase, then restart immediately.
        wr(2, 8, 1'b1, st);
        n = 0;
        while (m_pend[2] && n < 300) begin step(); n++; end
        step();
        wr(2, 8, 1'b0, st);
        n = 0;
        while (m_en[2] && n < 20) begin step(); n++; end
        check("ch2_active_drop", active[2], 0);
        check("ch2_clk_low", clk_out[2], 0);
        idle_steps(3);
        wr(2, 8, 1'b1, st);
        check("ch2_restart_tick", tick[2], 1);
        check("ch2_restart_clk", clk_out[2], 1);

        // Reset with a write pending on ch0.
        wr(0, 7, 1'b1, st);
        step();
        rst = 1'b1;
        step();
        check("midrst_clk", clk_out, 0);
        check("midrst_tick", tick, 0);
        u_if.cfg_ch = 2'd0;
        #1;
        check("midrst_ready", u_if.cfg_ready, 1);
        rst = 1'b0;
        tk = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            tk += int'(tick[0]);
        end
        check("postrst_ticks", tk, 2);

        // Random configuration traffic, including the out-of-range channel.
        for (int i = 0; i < 3000; i++) begin
            u_if.cfg_valid = ($urandom_range(0, 2) == 0);
            u_if.cfg_ch    = 2'($urandom_range(0, 3));
            u_if.cfg_div   = 16'($urandom_range(0, 13));
            u_if.cfg_en    = ($urandom_range(0, 3) != 0);
            rst            = ($urandom_range(0, 499) == 0);
            step();
        end
        u_if.cfg_valid = 1'b0;
        rst = 1'b0;
        idle_steps(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

endmodule
`default_nettype wire
